// File: rtl/adex_tdm_scheduler.sv
// Time-multiplexed AdEx scheduler: owns per-neuron V/w state, times simulation steps and
// sweeps every neuron through one shared datapath over a valid/ready request/response pair.
module adex_tdm_scheduler #(
    parameter int unsigned N        = 4,
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [15:0] V_INIT   = 16'hF000,
    localparam int unsigned IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           clr_flags,
    output logic           dp_req_valid,
    input  logic           dp_req_ready,
    output logic [IDW-1:0] dp_req_id,
    output logic [15:0]    dp_req_v,
    output logic [15:0]    dp_req_w,
    input  logic           dp_rsp_valid,
    input  logic [IDW-1:0] dp_rsp_id,
    input  logic [15:0]    dp_rsp_v,
    input  logic [15:0]    dp_rsp_w,
    input  logic           dp_rsp_spike,
    output logic [N-1:0]   spike_vec,
    output logic           spike_valid,
    output logic [15:0]    step_cnt,
    output logic           busy,
    input  logic [IDW-1:0] rd_sel,
    output logic [15:0]    rd_v,
    output logic [15:0]    rd_w,
    output logic           err_overrun,
    output logic           err_timeout
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned OW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StDone} state_e;

    state_e         state;
    logic [TW-1:0]  tick_cnt;
    logic [OW-1:0]  to_cnt;
    logic [IDW-1:0] idx;
    logic [N-1:0]   pend;
    logic [N-1:0]   pend_next;
    logic [15:0]    v_mem [N];
    logic [15:0]    w_mem [N];

    logic tick;
    logic to_hit;
    logic rsp_hit;
    logic adv;
    logic last;

    assign tick    = enable && (tick_cnt == TW'(TICK_DIV - 1));
    assign to_hit  = ((state == StIssue) || (state == StWaitRsp)) &&
                     (to_cnt == OW'(TIMEOUT - 1));
    assign rsp_hit = (state == StWaitRsp) && dp_rsp_valid && (dp_rsp_id == idx);
    // A response arriving on the timeout cycle takes precedence over the timeout.
    assign adv     = rsp_hit || to_hit;
    assign last    = (idx == IDW'(N - 1));

    // Request payload is a pure decode of registered state; it drops on the timeout cycle.
    assign dp_req_valid = (state == StIssue) && !to_hit;
    assign dp_req_id    = idx;
    assign dp_req_v     = v_mem[idx];
    assign dp_req_w     = w_mem[idx];

    always_comb begin
        pend_next = pend;
        if (rsp_hit) begin
            pend_next[idx] = dp_rsp_spike;
        end else if (to_hit) begin
            pend_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            tick_cnt    <= '0;
            to_cnt      <= '0;
            idx         <= '0;
            pend        <= '0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            step_cnt    <= '0;
            busy        <= 1'b0;
            rd_v        <= '0;
            rd_w        <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                v_mem[i] <= V_INIT;
                w_mem[i] <= '0;
            end
        end else begin
            spike_valid <= 1'b0;
            rd_v        <= v_mem[rd_sel];
            rd_w        <= w_mem[rd_sel];

            if (!enable || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (tick && (state != StIdle)) begin
                err_overrun <= 1'b1;
            end else if (clr_flags) begin
                err_overrun <= 1'b0;
            end

            if (to_hit && !rsp_hit) begin
                err_timeout <= 1'b1;
            end else if (clr_flags) begin
                err_timeout <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (tick) begin
                        idx    <= '0;
                        pend   <= '0;
                        to_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= StIssue;
                    end
                end
                StIssue, StWaitRsp: begin
                    to_cnt <= to_cnt + 1'b1;
                    pend   <= pend_next;
                    if (rsp_hit) begin
                        v_mem[idx] <= dp_rsp_v;
                        w_mem[idx] <= dp_rsp_w;
                    end
                    if (adv) begin
                        if (last) begin
                            // Publish on entry to DONE so the pulse lands 2N+1 cycles after tick.
                            spike_vec   <= pend_next;
                            spike_valid <= 1'b1;
                            step_cnt    <= step_cnt + 16'd1;
                            state       <= StDone;
                        end else begin
                            idx    <= idx + 1'b1;
                            to_cnt <= '0;
                            state  <= StIssue;
                        end
                    end else if ((state == StIssue) && dp_req_ready) begin
                        state <= StWaitRsp;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
